// File: rtl/som_pkg.sv
// Shared definitions for the SOM epoch scheduler slice.
//   - Default widths for sample address/count, learning rate, epoch count and
//     neighbourhood radius.
//   - Scheduler state encoding.
package som_pkg;

  localparam int ADDR_W = 18;  // sample address / per-epoch sample count
  localparam int LR_W   = 8;   // learning rate
  localparam int EP_W   = 4;   // epoch count
  localparam int RAD_W  = 3;   // neighbourhood radius

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DECAY = 3'd4,
    ST_WBACK = 3'd5,
    ST_FIN   = 3'd6
  } som_state_e;

endpackage

// File: rtl/som_epoch_sched_if.sv
// Scheduler <-> datapath/memory bus.
//   RAM_IF_A / RAM_IF_OE : input-feature RAM address and output enable
//   smp_valid / smp_ready: sample-address handshake to the update datapath
//   upd_idle             : datapath has no update in flight
//   wb_start / wb_done   : weight writeback request pulse / completion
// master = scheduler side, slave = datapath/memory side.
interface som_epoch_sched_if #(
  parameter int ADDR_W = som_pkg::ADDR_W
);
  logic [ADDR_W-1:0] RAM_IF_A;
  logic              RAM_IF_OE;
  logic              smp_valid;
  logic              smp_ready;
  logic              upd_idle;
  logic              wb_start;
  logic              wb_done;

  modport master (
    output RAM_IF_A, RAM_IF_OE, smp_valid, wb_start,
    input  smp_ready, upd_idle, wb_done
  );

  modport slave (
    input  RAM_IF_A, RAM_IF_OE, smp_valid, wb_start,
    output smp_ready, upd_idle, wb_done
  );
endinterface

// File: rtl/som_decay_unit.sv
// Per-epoch coefficient decay (purely combinational).
//   lr_in  -> lr_out  : lr - (lr >> 2), never below 1
//   rad_in -> rad_out : radius - 1, saturating at 0
module som_decay_unit #(
  parameter int LR_W  = som_pkg::LR_W,
  parameter int RAD_W = som_pkg::RAD_W
) (
  input  logic [LR_W-1:0]  lr_in,
  input  logic [RAD_W-1:0] rad_in,
  output logic [LR_W-1:0]  lr_out,
  output logic [RAD_W-1:0] rad_out
);

  logic [LR_W-1:0] lr_diff;

  // lr >> 2 never exceeds lr, so the subtraction cannot wrap.
  assign lr_diff = lr_in - (lr_in >> 2);
  assign lr_out  = (lr_diff == '0) ? LR_W'(1) : lr_diff;
  assign rad_out = (rad_in == '0) ? '0 : rad_in - RAD_W'(1);

endmodule

// File: rtl/som_epoch_sched.sv
// SOM training epoch scheduler.
// Walks the input-feature RAM once per epoch, handing each sample address to
// the update datapath, waits for the datapath to drain, decays learning rate
// and radius, and after the last epoch requests a weight writeback.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   start                 : run request (honoured only in IDLE/FIN)
//   cfg_epochs/samples    : run length, latched when a run is accepted
//   cfg_lr_init/rad_init  : initial coefficients, latched with the run
//   sif (master)          : RAM address/OE, sample handshake, upd_idle,
//                           writeback handshake
//   lr, radius            : current training coefficients
//   epoch_cnt             : completed epochs
//   busy, done            : run status
// Every output is a register or a decode of state/registers.
module som_epoch_sched #(
  parameter int ADDR_W = som_pkg::ADDR_W,
  parameter int LR_W   = som_pkg::LR_W,
  parameter int EP_W   = som_pkg::EP_W,
  parameter int RAD_W  = som_pkg::RAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EP_W-1:0]   cfg_epochs,
  input  logic [ADDR_W-1:0] cfg_samples,
  input  logic [LR_W-1:0]   cfg_lr_init,
  input  logic [RAD_W-1:0]  cfg_rad_init,
  som_epoch_sched_if.master sif,
  output logic [LR_W-1:0]   lr,
  output logic [RAD_W-1:0]  radius,
  output logic [EP_W-1:0]   epoch_cnt,
  output logic              busy,
  output logic              done
);

  som_pkg::som_state_e state, nxt;

  logic [ADDR_W-1:0] smp_idx, samples_q;
  logic [EP_W-1:0]   epochs_q, ep_q, ep_inc;
  logic [LR_W-1:0]   lr_init_q, lr_q, lr_dec;
  logic [RAD_W-1:0]  rad_init_q, rad_q, rad_dec;
  logic              wb_first;
  logic              idle_like, cfg_zero, run_accept;
  logic              xfer, last_xfer;

  som_decay_unit #(.LR_W(LR_W), .RAD_W(RAD_W)) u_decay (
    .lr_in  (lr_q),
    .rad_in (rad_q),
    .lr_out (lr_dec),
    .rad_out(rad_dec)
  );

  assign idle_like  = (state == som_pkg::ST_IDLE) || (state == som_pkg::ST_FIN);
  assign cfg_zero   = (cfg_epochs == '0) || (cfg_samples == '0);
  assign run_accept = idle_like && start && !cfg_zero;

  // samples_q is never 0 inside a run, so samples_q-1 does not wrap and the
  // compare covers the full 2^ADDR_W-1 range.
  assign xfer      = (state == som_pkg::ST_ISSUE) && sif.smp_ready;
  assign last_xfer = xfer && (smp_idx == samples_q - ADDR_W'(1));
  assign ep_inc    = ep_q + EP_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= som_pkg::ST_IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      som_pkg::ST_IDLE,
      som_pkg::ST_FIN:   if (start) nxt = cfg_zero ? som_pkg::ST_FIN : som_pkg::ST_LOAD;
      som_pkg::ST_LOAD:  nxt = som_pkg::ST_ISSUE;
      som_pkg::ST_ISSUE: if (last_xfer) nxt = som_pkg::ST_DRAIN;
      som_pkg::ST_DRAIN: if (sif.upd_idle) nxt = som_pkg::ST_DECAY;
      som_pkg::ST_DECAY: nxt = (ep_inc == epochs_q) ? som_pkg::ST_WBACK : som_pkg::ST_ISSUE;
      som_pkg::ST_WBACK: if (sif.wb_done) nxt = som_pkg::ST_FIN;
      default:           nxt = som_pkg::ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    sif.smp_valid = 1'b0;
    sif.RAM_IF_OE = 1'b0;
    sif.wb_start  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      som_pkg::ST_ISSUE: begin
        sif.smp_valid = 1'b1;
        sif.RAM_IF_OE = 1'b1;
        busy          = 1'b1;
      end
      som_pkg::ST_LOAD,
      som_pkg::ST_DRAIN,
      som_pkg::ST_DECAY: busy = 1'b1;
      som_pkg::ST_WBACK: begin
        busy         = 1'b1;
        sif.wb_start = wb_first;
      end
      som_pkg::ST_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign sif.RAM_IF_A = smp_idx;
  assign lr           = lr_q;
  assign radius       = rad_q;
  assign epoch_cnt    = ep_q;

  // Datapath registers. Config is captured on the accepting edge so that
  // anything the host does to cfg_* once busy is up has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_idx    <= '0;
      samples_q  <= '0;
      epochs_q   <= '0;
      ep_q       <= '0;
      lr_init_q  <= '0;
      lr_q       <= '0;
      rad_init_q <= '0;
      rad_q      <= '0;
      wb_first   <= 1'b0;
    end else begin
      if (run_accept) begin
        samples_q  <= cfg_samples;
        epochs_q   <= cfg_epochs;
        lr_init_q  <= cfg_lr_init;
        rad_init_q <= cfg_rad_init;
      end
      // Marks the first WBACK cycle so wb_start is a single pulse.
      wb_first <= (nxt == som_pkg::ST_WBACK) && (state != som_pkg::ST_WBACK);
      case (state)
        som_pkg::ST_LOAD: begin
          lr_q    <= lr_init_q;
          rad_q   <= rad_init_q;
          smp_idx <= '0;
          ep_q    <= '0;
        end
        som_pkg::ST_ISSUE: begin
          if (xfer) smp_idx <= last_xfer ? '0 : smp_idx + ADDR_W'(1);
        end
        som_pkg::ST_DECAY: begin
          lr_q  <= lr_dec;
          rad_q <= rad_dec;
          ep_q  <= ep_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_som_epoch_sched.sv
// Directed bench for som_epoch_sched.
module tb_som_epoch_sched;

  localparam int ADDR_W = 18;
  localparam int LR_W   = 8;
  localparam int EP_W   = 4;
  localparam int RAD_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [EP_W-1:0]   cfg_epochs;
  logic [ADDR_W-1:0] cfg_samples;
  logic [LR_W-1:0]   cfg_lr_init;
  logic [RAD_W-1:0]  cfg_rad_init;
  logic [LR_W-1:0]   lr;
  logic [RAD_W-1:0]  radius;
  logic [EP_W-1:0]   epoch_cnt;
  logic              busy, done;

  som_epoch_sched_if #(.ADDR_W(ADDR_W)) sif ();

  som_epoch_sched #(.ADDR_W(ADDR_W), .LR_W(LR_W), .EP_W(EP_W), .RAD_W(RAD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_epochs  (cfg_epochs),
    .cfg_samples (cfg_samples),
    .cfg_lr_init (cfg_lr_init),
    .cfg_rad_init(cfg_rad_init),
    .sif         (sif),
    .lr          (lr),
    .radius      (radius),
    .epoch_cnt   (epoch_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Transfer and writeback log, written only here.
  logic [ADDR_W-1:0] addr_q[$];
  int                wb_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (sif.smp_valid && sif.smp_ready) addr_q.push_back(sif.RAM_IF_A);
      if (sif.wb_start) wb_cnt++;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int ep, input int smp, input int lri, input int rad);
    cfg_epochs   = EP_W'(ep);
    cfg_samples  = ADDR_W'(smp);
    cfg_lr_init  = LR_W'(lri);
    cfg_rad_init = RAD_W'(rad);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    while (!sif.wb_start && n < 300) begin tick(); n++; end
    chk(tag, sif.wb_start, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk(tag, done, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lr"},   lr, 0);
    chk({tag, "_rad"},  radius, 0);
    chk({tag, "_ep"},   epoch_cnt, 0);
    chk({tag, "_addr"}, sif.RAM_IF_A, 0);
    chk({tag, "_oe"},   sif.RAM_IF_OE, 0);
    chk({tag, "_vld"},  sif.smp_valid, 0);
    chk({tag, "_wbs"},  sif.wb_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic chk_addrs(input string tag, input int base, input int smp, input int ep);
    chk({tag, "_ntx"}, addr_q.size() - base, smp * ep);
    for (int i = 0; i < smp * ep; i++)
      if (base + i < addr_q.size()) chk({tag, "_addr"}, addr_q[base + i], i % smp);
  endtask

  initial begin
    int a0, w0, nstall, nbad;
    logic stall;
    logic [ADDR_W-1:0] pa;

    rst = 1'b1; start = 1'b0;
    cfg_epochs = '0; cfg_samples = '0; cfg_lr_init = '0; cfg_rad_init = '0;
    sif.smp_ready = 1'b1; sif.upd_idle = 1'b1; sif.wb_done = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b0;

    // samples=0 -> FIN after one edge, nothing loaded, no writeback
    w0 = wb_cnt;
    start_run(2, 0, 10, 1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_lr",   lr, 0);
    tick();
    chk("zero_wb",   wb_cnt - w0, 0);

    // Basic run, config scrambled and start re-pulsed once busy
    a0 = addr_q.size(); w0 = wb_cnt;
    start_run(2, 4, 64, 3);                  // LOAD
    chk("t1_load_busy", busy, 1);
    start_run(1, 7, 200, 5);                 // scrambled cfg + start, now ISSUE
    chk("t1_iss_vld", sif.smp_valid, 1);
    chk("t1_iss_oe",  sif.RAM_IF_OE, 1);
    chk("t1_iss_a",   sif.RAM_IF_A, 0);
    chk("t1_iss_lr",  lr, 64);
    chk("t1_iss_rad", radius, 3);
    start = 1'b1; tick(); start = 1'b0;      // transfer 0 with start held
    repeat (5) tick();                       // t1..t3, DRAIN, DECAY -> ISSUE
    chk("t1_e1_lr",  lr, 48);
    chk("t1_e1_rad", radius, 2);
    chk("t1_e1_ep",  epoch_cnt, 1);
    chk("t1_e1_a",   sif.RAM_IF_A, 0);
    wait_wb("t1_wb_seen");
    chk("t1_lr",  lr, 36);
    chk("t1_rad", radius, 1);
    chk("t1_ep",  epoch_cnt, 2);
    tick(); tick();
    chk("t1_wb_pulse", sif.wb_start, 0);
    chk("t1_wb_busy",  busy, 1);
    chk("t1_wb_done0", done, 0);
    sif.wb_done = 1'b1; tick(); sif.wb_done = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_wbcnt", wb_cnt - w0, 1);
    chk_addrs("t1", a0, 4, 2);
    tick();
    chk("t1_fin_lr", lr, 36);

    // smp_ready toggling; wb_done held high throughout
    a0 = addr_q.size(); w0 = wb_cnt; nstall = 0;
    sif.wb_done = 1'b1;
    start_run(2, 3, 100, 2);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      sif.smp_ready = (i % 2 == 1);
      stall = sif.smp_valid && !sif.smp_ready;
      pa = sif.RAM_IF_A;
      tick();
      if (stall) begin
        nstall++;
        chk("t2_stall_hold", sif.RAM_IF_A, pa);
      end
    end
    chk("t2_done",   done, 1);
    chk("t2_stalls", nstall > 0, 1);
    chk("t2_lr",     lr, 57);
    chk("t2_rad",    radius, 0);
    chk("t2_ep",     epoch_cnt, 2);
    chk("t2_wbcnt",  wb_cnt - w0, 1);
    chk_addrs("t2", a0, 3, 2);
    sif.smp_ready = 1'b1;
    sif.wb_done = 1'b0;

    // DRAIN held by upd_idle; DECAY one cycle after it rises
    sif.upd_idle = 1'b0;
    start_run(1, 2, 80, 1);                  // LOAD
    tick(); tick(); tick();                  // ISSUE, t0, t1 -> DRAIN
    chk("t4_drain_vld",  sif.smp_valid, 0);
    chk("t4_drain_busy", busy, 1);
    repeat (5) tick();
    chk("t4_hold_ep",   epoch_cnt, 0);
    chk("t4_hold_busy", busy, 1);
    sif.upd_idle = 1'b1;
    tick();                                  // DECAY
    chk("t4_decay_ep", epoch_cnt, 0);
    chk("t4_decay_lr", lr, 80);
    tick();                                  // WBACK
    chk("t4_ep",  epoch_cnt, 1);
    chk("t4_lr",  lr, 60);
    chk("t4_rad", radius, 0);
    chk("t4_wbs", sif.wb_start, 1);
    sif.wb_done = 1'b1; tick(); sif.wb_done = 1'b0;  // same-cycle wb_done
    chk("t4_done", done, 1);

    // lr floor at 1, radius floor at 0
    nbad = 0;
    sif.wb_done = 1'b1;
    start_run(3, 2, 1, 0);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tick();
      if (sif.smp_valid && (lr != 1 || radius != 0)) nbad++;
    end
    chk("t3_done", done, 1);
    chk("t3_bad",  nbad, 0);
    chk("t3_lr",   lr, 1);
    chk("t3_rad",  radius, 0);
    chk("t3_ep",   epoch_cnt, 3);
    sif.wb_done = 1'b0;

    // Reset during WBACK, then a fresh run
    start_run(1, 1, 50, 2);
    wait_wb("t6_wb_seen");
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all_zero("t6_rst");
    tick();
    chk("t6_idle_done", done, 0);
    a0 = addr_q.size(); w0 = wb_cnt;
    sif.wb_done = 1'b1;
    start_run(2, 4, 64, 3);
    wait_done("t6_done");
    chk("t6_lr",    lr, 36);
    chk("t6_rad",   radius, 1);
    chk("t6_ep",    epoch_cnt, 2);
    chk("t6_wbcnt", wb_cnt - w0, 1);
    chk_addrs("t6", a0, 4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/som_epoch_sched.md
SOM_EPOCH_SCHED -- requirements
Module: som_epoch_sched

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, sample address and count width.
REQ-002 The block SHALL have parameter LR_W, default 8, learning-rate width.
REQ-003 The block SHALL have parameter EP_W, default 4, epoch count width.
REQ-004 The block SHALL have parameter RAD_W, default 3, neighbourhood radius width.
REQ-005 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: pulse to begin a training run.
REQ-007 The block SHALL have port cfg_epochs, input, EP_W bits: number of epochs.
REQ-008 The block SHALL have port cfg_samples, input, ADDR_W bits: input vectors per epoch.
REQ-009 The block SHALL have port cfg_lr_init, input, LR_W bits: initial learning rate.
REQ-010 The block SHALL have port cfg_rad_init, input, RAD_W bits: initial radius.
REQ-011 The block SHALL have port RAM_IF_A, output, ADDR_W bits: input-feature RAM address.
REQ-012 The block SHALL have port RAM_IF_OE, output, 1 bit: input-feature RAM output enable.
REQ-013 The block SHALL have port smp_valid, output, 1 bit: sample address valid to the datapath.
REQ-014 The block SHALL have port smp_ready, input, 1 bit: the datapath accepts a sample.
REQ-015 The block SHALL have port upd_idle, input, 1 bit: the datapath has no update in flight.
REQ-016 The block SHALL have ports lr (LR_W) and radius (RAD_W), both outputs: current training coefficients.
REQ-017 The block SHALL have port epoch_cnt, output, EP_W bits: count of completed epochs.
REQ-018 The block SHALL have port wb_start, output, 1 bit: one-cycle pulse requesting weight writeback.
REQ-019 The block SHALL have port wb_done, input, 1 bit: the writeback is complete.
REQ-020 The block SHALL have ports busy and done, both outputs, 1 bit each: run status.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, ISSUE, DRAIN, DECAY, WBACK, FIN.
REQ-022 In IDLE or FIN, start with cfg_epochs or cfg_samples equal to 0 SHALL go to FIN; any other start SHALL go to LOAD.
REQ-023 LOAD SHALL take 1 cycle; it SHALL latch the config, set lr to cfg_lr_init, radius to cfg_rad_init, smp_idx and epoch_cnt to 0, then go to ISSUE.
REQ-024 In ISSUE, smp_valid, RAM_IF_OE and busy SHALL be 1, and RAM_IF_A SHALL equal smp_idx.
REQ-025 While smp_ready is 0 in ISSUE, smp_idx SHALL hold.
REQ-026 A transfer SHALL be smp_valid and smp_ready both 1; on a transfer, smp_idx SHALL increment.
REQ-027 On the transfer where smp_idx equals samples-1, the FSM SHALL go to DRAIN and smp_idx SHALL clear to 0; full-range 2^ADDR_W-1 SHALL be supported without overflow.
REQ-028 In DRAIN, smp_valid SHALL be 0 and the FSM SHALL wait for upd_idle equal to 1, then go to DECAY.
REQ-029 DECAY SHALL take 1 cycle: lr becomes lr-(lr>>2) with a floor of 1, radius decrements saturating at 0, and epoch_cnt increments.
REQ-030 At the end of DECAY, the FSM SHALL go to WBACK if the new epoch_cnt equals cfg_epochs, and to ISSUE otherwise.
REQ-031 wb_start SHALL be 1 only in the first cycle of WBACK; the FSM SHALL stay in WBACK until wb_done is 1, then go to FIN.
REQ-032 wb_done arriving in the same cycle as wb_start SHALL be accepted.
REQ-033 In FIN, done SHALL be 1, busy 0, and lr, radius and epoch_cnt SHALL be held.
REQ-034 busy SHALL be 1 in LOAD, ISSUE, DRAIN, DECAY and WBACK.
REQ-035 start SHALL be ignored while busy is 1, and config changes while busy is 1 SHALL have no effect.
REQ-036 wb_done outside WBACK and smp_ready outside ISSUE SHALL be ignored.
REQ-037 All outputs SHALL be registered or decoded from state and registers only, with no input-to-output combinational path except none.

Reset
REQ-038 When rst is 1 at a clock edge, the state SHALL become IDLE and every output SHALL become 0, including lr, radius, epoch_cnt, RAM_IF_A, done and busy.
REQ-039 A reset in the middle of a run SHALL abort the run without issuing wb_start, and the next start SHALL begin a fresh run.

Structure
REQ-040 The state encoding and the width constants ADDR_W, LR_W, EP_W and RAD_W SHALL reside in the shared package som_pkg.
REQ-041 The lr/radius decay arithmetic SHALL be a combinational sub-module named som_decay_unit.

Verification
REQ-042 Bench: epochs=2, samples=4, lr_init=64, rad=3, smp_ready tied 1 -> addresses 0,1,2,3 twice; lr 64→48→36; radius 3→2→1; epoch_cnt=2; one wb_start; done=1.
REQ-043 Bench: smp_ready toggled 1/0 each cycle -> RAM_IF_A holds during stalls; exactly samples transfers per epoch.
REQ-044 Bench: lr_init=1, rad=0, epochs=3 -> lr stays 1 and radius stays 0.
REQ-045 Bench: upd_idle low for 5 cycles after the last transfer -> DECAY is entered exactly 1 cycle after upd_idle rises.
REQ-046 Bench: samples=0 -> FIN in 1 cycle with no wb_start; start pulsed mid-ISSUE -> ignored.
REQ-047 Bench: rst pulsed in WBACK -> IDLE with all outputs 0; a following start gives a full correct run.
